// File: rtl/program_loader.sv
// Boot loader: receives a length-prefixed little-endian program image over a byte
// stream, writes it word by word into instruction ROM, then acknowledges and releases the CPU.
module program_loader #(
    parameter int         ROM_ADDRESS_BITWIDTH = 10,
    parameter logic [7:0] ACK_OK               = 8'hAA,
    parameter logic [7:0] ACK_ERR              = 8'hEE
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_write_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            load_done,
    output logic                            load_error
);

    localparam int          INDEX_BITS = ROM_ADDRESS_BITWIDTH - 1;
    localparam logic [31:0] CAPACITY   = 32'd1 << (ROM_ADDRESS_BITWIDTH - 2);

    typedef enum logic [2:0] {
        RECV_COUNT,
        RECV_WORD,
        WRITE,
        DONE,
        RUN,
        ERROR
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [1:0]              byte_cnt;
    logic [31:0]             shift_word;
    logic [31:0]             word_count;
    logic [INDEX_BITS-1:0]   word_index;
    logic                    err_ack_sent;
    logic [31:0]             assembled;
    logic [31:0]             next_index;
    logic                    rx_fire;
    logic                    last_byte;

    // Bytes shift in from the top so the first byte lands in bits [7:0] after four transfers.
    assign assembled  = {rx_data, shift_word[31:8]};
    assign rx_ready   = (state == RECV_COUNT) || (state == RECV_WORD);
    assign rx_fire    = rx_valid & rx_ready;
    assign last_byte  = rx_fire && (byte_cnt == 2'd3);
    assign next_index = 32'(word_index) + 32'd1;

    assign rom_wren          = (state == WRITE);
    assign rom_write_address = {word_index[INDEX_BITS-2:0], 2'b00};
    assign rom_write_data    = shift_word;
    assign cpu_reset_n       = (state == RUN);
    assign load_done         = (state == RUN);
    assign load_error        = (state == ERROR);
    assign tx_valid          = (state == DONE) || ((state == ERROR) && !err_ack_sent);
    assign tx_data           = (state == DONE) ? ACK_OK :
                               ((state == ERROR) && !err_ack_sent) ? ACK_ERR : 8'h00;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RECV_COUNT;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            byte_cnt     <= 2'd0;
            shift_word   <= 32'd0;
            word_count   <= 32'd0;
            word_index   <= '0;
            err_ack_sent <= 1'b0;
        end else begin
            if (rx_fire) begin
                byte_cnt   <= byte_cnt + 2'd1;
                shift_word <= assembled;
            end
            if ((state == RECV_COUNT) && last_byte) begin
                word_count <= assembled;
            end
            if (state == WRITE) begin
                word_index <= word_index + INDEX_BITS'(1);
            end
            if ((state == ERROR) && tx_valid && tx_ready) begin
                err_ack_sent <= 1'b1;
            end
        end
    end

    // The count check is done at the full 32-bit width so huge counts never alias.
    always_comb begin
        next_state = state;
        case (state)
            RECV_COUNT: begin
                if (last_byte) begin
                    if (assembled == 32'd0) begin
                        next_state = DONE;
                    end else if (assembled > CAPACITY) begin
                        next_state = ERROR;
                    end else begin
                        next_state = RECV_WORD;
                    end
                end
            end
            RECV_WORD: begin
                if (last_byte) begin
                    next_state = WRITE;
                end
            end
            WRITE: begin
                next_state = (next_index == word_count) ? DONE : RECV_WORD;
            end
            DONE: begin
                if (tx_ready) begin
                    next_state = RUN;
                end
            end
            RUN:     next_state = RUN;
            ERROR:   next_state = ERROR;
            default: next_state = RECV_COUNT;
        endcase
    end

endmodule

// File: tb/tb_program_loader.sv
// Randomized self-checking bench for program_loader; expected ROM writes and
// acknowledges come from a simple image model (word i lands at byte address 4*i).
module tb_program_loader;

    localparam int AW  = 10;
    localparam int CAP = 1 << (AW - 2);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          rom_wren;
    logic [AW-1:0] rom_write_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          load_done;
    logic          load_error;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         seen_writes[$];
    wr_t         mon_w;
    logic [31:0] img[$];

    program_loader #(.ROM_ADDRESS_BITWIDTH(AW), .ACK_OK(8'hAA), .ACK_ERR(8'hEE)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .rx_data           (rx_data),
        .rx_valid          (rx_valid),
        .rx_ready          (rx_ready),
        .tx_data           (tx_data),
        .tx_valid          (tx_valid),
        .tx_ready          (tx_ready),
        .rom_wren          (rom_wren),
        .rom_write_address (rom_write_address),
        .rom_write_data    (rom_write_data),
        .cpu_reset_n       (cpu_reset_n),
        .load_done         (load_done),
        .load_error        (load_error)
    );

    always #5 clk = ~clk;

    // Every ROM write strobe seen between edges is logged for comparison against the image.
    always @(negedge clk) begin
        if (reset_n && rom_wren === 1'b1) begin
            mon_w.addr = rom_write_address;
            mon_w.data = rom_write_data;
            seen_writes.push_back(mon_w);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] expected_ack(input logic [31:0] n);
        return (n > CAP) ? 8'hEE : 8'hAA;
    endfunction

    task automatic do_reset();
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        seen_writes.delete();
    endtask

    // Presents one byte and returns just after the edge on which it was accepted.
    task automatic applyStimulus(input logic [7:0] b, input bit gaps, output bit ok);
        int budget;
        ok = 1'b1;
        if (gaps) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
        end
        rx_data  = b;
        rx_valid = 1'b1;
        budget   = 0;
        forever begin
            @(negedge clk);
            if (rx_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            budget++;
            if (budget > 50) begin
                ok = 1'b0;
                break;
            end
        end
    endtask

    task automatic send_word(input logic [31:0] w, input bit gaps, output bit ok);
        bit b_ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(w[8*i +: 8], gaps, b_ok);
            ok &= b_ok;
        end
    endtask

    task automatic send_image(input bit gaps, output bit ok);
        bit w_ok;
        send_word(32'(img.size()), gaps, ok);
        foreach (img[i]) begin
            send_word(img[i], gaps, w_ok);
            ok &= w_ok;
        end
    endtask

    // Returns on a negative edge at which tx_valid is high, or with ok=0 after a bounded wait.
    task automatic wait_tx(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (tx_valid === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_handshake();
        tx_ready = 1'b1;
        @(posedge clk);
        #1;
        tx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic random_image(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom());
    endtask

    task automatic test_reset();
        logic [55:0] expv;
        expv = {1'b1, 1'b0, 8'h00, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0};
        reset_n = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({rx_ready, tx_valid, tx_data, rom_wren, rom_write_address, rom_write_data,
             cpu_reset_n, load_done, load_error} !== expv) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got %h expected %h",
                     {rx_ready, tx_valid, tx_data, rom_wren, rom_write_address, rom_write_data,
                      cpu_reset_n, load_done, load_error}, expv);
        end
    endtask

    task automatic test_two_words();
        bit ok;
        bit ok2;
        do_reset();
        img = '{32'h00100513, 32'h00200593};
        send_word(32'd2, 1'b0, ok);
        send_word(img[0], 1'b0, ok2);
        ok &= ok2;
        @(negedge clk);
        n_checks++;
        if ({rom_wren, rom_write_address, rom_write_data} !== {1'b1, {AW{1'b0}}, 32'h00100513}) begin
            n_fail++;
            $display("[TB] FAIL first_write_latency: got %b/%h/%h expected 1/000/00100513",
                     rom_wren, rom_write_address, rom_write_data);
        end
        send_word(img[1], 1'b0, ok2);
        ok &= ok2;
        wait_tx(ok2);
        ok &= ok2;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("[TB] FAIL two_words_progress: got timeout expected handshakes");
        end
        n_checks++;
        if ({tx_data, cpu_reset_n} !== {8'hAA, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL two_words_ack: got %h/%b expected aa/0", tx_data, cpu_reset_n);
        end
        do_handshake();
        n_checks++;
        if ({tx_valid, cpu_reset_n, load_done, load_error, rx_ready} !== 5'b01100) begin
            n_fail++;
            $display("[TB] FAIL two_words_release: got %b expected 01100",
                     {tx_valid, cpu_reset_n, load_done, load_error, rx_ready});
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (seen_writes.size() !== 2) begin
            n_fail++;
            $display("[TB] FAIL two_words_count: got %0d writes expected 2", seen_writes.size());
        end else begin
            for (int i = 0; i < 2; i++) begin
                n_checks++;
                if (seen_writes[i].addr !== AW'(i * 4) || seen_writes[i].data !== img[i]) begin
                    n_fail++;
                    $display("[TB] FAIL two_words_data[%0d]: got %h@%h expected %h@%h", i,
                             seen_writes[i].data, seen_writes[i].addr, img[i], AW'(i * 4));
                end
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_count_zero();
        bit ok;
        bit ok2;
        do_reset();
        tx_ready = 1'b1;
        send_word(32'd0, 1'b0, ok);
        wait_tx(ok2);
        n_checks++;
        if (!(ok && ok2) || tx_data !== expected_ack(32'd0)) begin
            n_fail++;
            $display("[TB] FAIL count_zero_ack: got %h ok=%b expected aa", tx_data, ok && ok2);
        end
        @(negedge clk);
        n_checks++;
        if ({tx_valid, cpu_reset_n, load_done, load_error} !== 4'b0110 || seen_writes.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL count_zero_done: got %b writes=%0d expected 0110 writes=0",
                     {tx_valid, cpu_reset_n, load_done, load_error}, seen_writes.size());
        end
        tx_ready = 1'b0;
        rx_valid = 1'b0;
    endtask

    task automatic test_oversize();
        bit ok;
        do_reset();
        send_word(32'(CAP + 1), 1'b0, ok);
        rx_data = 8'h55;
        @(negedge clk);
        n_checks++;
        if (!ok || {load_error, tx_valid, tx_data, rx_ready, cpu_reset_n} !== {1'b1, 1'b1, expected_ack(32'(CAP + 1)), 1'b0, 1'b0}) begin
            n_fail++;
            $display("[TB] FAIL oversize_entry: got err=%b txv=%b tx=%h rdy=%b cpu=%b expected 1 1 ee 0 0",
                     load_error, tx_valid, tx_data, rx_ready, cpu_reset_n);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_valid, tx_data, rx_ready} !== {1'b1, 8'hEE, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL oversize_hold: got %b/%h/%b expected 1/ee/0", tx_valid, tx_data, rx_ready);
            end
        end
        do_handshake();
        n_checks++;
        if ({tx_valid, load_error, load_done, cpu_reset_n, rx_ready} !== 5'b01000 || seen_writes.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL oversize_after: got %b writes=%0d expected 01000 writes=0",
                     {tx_valid, load_error, load_done, cpu_reset_n, rx_ready}, seen_writes.size());
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_capacity();
        bit ok;
        bit ok2;
        int errs;
        do_reset();
        random_image(CAP);
        send_image(1'b0, ok);
        wait_tx(ok2);
        n_checks++;
        if (!(ok && ok2) || tx_data !== expected_ack(32'(CAP))) begin
            n_fail++;
            $display("[TB] FAIL capacity_ack: got %h ok=%b expected aa", tx_data, ok && ok2);
        end
        do_handshake();
        n_checks++;
        if ({load_done, cpu_reset_n, load_error} !== 3'b110) begin
            n_fail++;
            $display("[TB] FAIL capacity_done: got %b expected 110", {load_done, cpu_reset_n, load_error});
        end
        n_checks++;
        if (seen_writes.size() != CAP || seen_writes[seen_writes.size() - 1].addr !== AW'(1020)) begin
            n_fail++;
            $display("[TB] FAIL capacity_last: got %0d writes last@%h expected %0d writes last@3fc",
                     seen_writes.size(),
                     (seen_writes.size() > 0) ? seen_writes[seen_writes.size() - 1].addr : {AW{1'b0}}, CAP);
        end else begin
            errs = 0;
            foreach (img[i]) begin
                if (seen_writes[i].addr !== AW'(i * 4) || seen_writes[i].data !== img[i]) errs++;
            end
            n_checks++;
            if (errs != 0) begin
                n_fail++;
                $display("[TB] FAIL capacity_data: got %0d wrong words expected 0", errs);
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic test_backpressure();
        bit ok;
        bit ok2;
        do_reset();
        random_image($urandom_range(3, 8));
        send_image(1'b1, ok);
        wait_tx(ok2);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if ({tx_valid, tx_data, cpu_reset_n, load_done} !== {1'b1, 8'hAA, 1'b0, 1'b0}) begin
                n_fail++;
                $display("[TB] FAIL tx_backpressure: got %b/%h/%b/%b expected 1/aa/0/0",
                         tx_valid, tx_data, cpu_reset_n, load_done);
            end
        end
        do_handshake();
        n_checks++;
        if (!(ok && ok2) || {tx_valid, cpu_reset_n, load_done} !== 3'b011) begin
            n_fail++;
            $display("[TB] FAIL backpressure_release: got %b ok=%b expected 011",
                     {tx_valid, cpu_reset_n, load_done}, ok && ok2);
        end
        n_checks++;
        if (seen_writes.size() != img.size()) begin
            n_fail++;
            $display("[TB] FAIL backpressure_count: got %0d expected %0d", seen_writes.size(), img.size());
        end else begin
            foreach (img[i]) begin
                n_checks++;
                if (seen_writes[i].addr !== AW'(i * 4) || seen_writes[i].data !== img[i]) begin
                    n_fail++;
                    $display("[TB] FAIL backpressure_data[%0d]: got %h@%h expected %h@%h", i,
                             seen_writes[i].data, seen_writes[i].addr, img[i], AW'(i * 4));
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit ok2;
        int errs;
        for (int it = 0; it < 3; it++) begin
            do_reset();
            random_image($urandom_range(1, 6));
            send_image(1'($urandom_range(0, 1)), ok);
            wait_tx(ok2);
            n_checks++;
            if (!(ok && ok2) || tx_data !== expected_ack(32'(img.size()))) begin
                n_fail++;
                $display("[TB] FAIL b2b_ack[%0d]: got %h ok=%b expected aa", it, tx_data, ok && ok2);
            end
            do_handshake();
            errs = (seen_writes.size() == img.size()) ? 0 : 1;
            if (errs == 0) begin
                foreach (img[i]) begin
                    if (seen_writes[i].addr !== AW'(i * 4) || seen_writes[i].data !== img[i]) errs++;
                end
            end
            n_checks++;
            if (errs != 0 || load_done !== 1'b1) begin
                n_fail++;
                $display("[TB] FAIL b2b_image[%0d]: got %0d bad writes done=%b expected 0 bad done=1",
                         it, errs, load_done);
            end
        end
    endtask

    task automatic test_reset_mid_load();
        bit ok;
        bit ok2;
        logic [55:0] expv;
        expv = {1'b1, 1'b0, 8'h00, 1'b0, {AW{1'b0}}, 32'h0, 1'b0, 1'b0, 1'b0};
        do_reset();
        send_word(32'd2, 1'b0, ok);
        send_word(32'hCAFEF00D, 1'b0, ok2);
        applyStimulus(8'h11, 1'b0, ok2);
        applyStimulus(8'h22, 1'b0, ok2);
        rx_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({rx_ready, tx_valid, tx_data, rom_wren, rom_write_address, rom_write_data,
             cpu_reset_n, load_done, load_error} !== expv) begin
            n_fail++;
            $display("[TB] FAIL async_reset: got %h expected %h",
                     {rx_ready, tx_valid, tx_data, rom_wren, rom_write_address, rom_write_data,
                      cpu_reset_n, load_done, load_error}, expv);
        end
        do_reset();
        random_image(1);
        send_image(1'b0, ok);
        wait_tx(ok2);
        do_handshake();
        n_checks++;
        if (!(ok && ok2) || seen_writes.size() != 1 || load_done !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reload_count: got %0d writes done=%b expected 1 write done=1",
                     seen_writes.size(), load_done);
        end else begin
            n_checks++;
            if (seen_writes[0].addr !== {AW{1'b0}} || seen_writes[0].data !== img[0]) begin
                n_fail++;
                $display("[TB] FAIL reload_data: got %h@%h expected %h@000",
                         seen_writes[0].data, seen_writes[0].addr, img[0]);
            end
        end
        rx_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_two_words();
        test_count_zero();
        test_oversize();
        test_capacity();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_load();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
